classifier_frame_feeder: RTL and testbench

- Synthesizable environment side of the ClassifierPipeline input interface.
- Takes a byte stream of pixels through a valid/ready handshake and assembles 784-pixel frames in a two-bank (ping-pong) buffer.
- Serves the classifier's frame-read port and exposes the input_valid flag. The classifier clears that flag to release a frame, which swaps banks.
- Replaces the behavioural image RAM and flag logic with hardware that can sit in front of the classifier on-chip.

---
 rtl/classifier_frame_feeder.sv | 111 +++++++++++
 tb/tb_classifier_frame_feeder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/classifier_frame_feeder.sv
// Ping-pong frame buffer in front of the classifier: streams pixels into two banks, 1-cycle registered read, valid flag released by the classifier.
// Backpressure: pix_in_ready drops while both banks are full. Optional FEEDER_FRAME_STATS_EN adds frame counters.
module classifier_frame_feeder #(
   parameter int PIXELS_PER_FRAME = 784,
   parameter int PIXEL_W          = 8,
   parameter int RD_DATA_W        = 16,
   parameter int ADDR_W           = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [PIXEL_W-1:0]   pix_in_data,
   input  logic                 pix_in_valid,
   output logic                 pix_in_ready,
   input  logic [ADDR_W-1:0]    classifier_input_address_a,
   output logic [RD_DATA_W-1:0] classifier_input_read_data_a,
   output logic [7:0]           classifier_input_valid_read_data,
   input  logic                 classifier_input_valid_write_en,
   input  logic [7:0]           classifier_input_valid_write_data,
`ifdef FEEDER_FRAME_STATS_EN
   output logic [15:0]          frames_released,
   output logic [1:0]           frames_pending,
`endif
   output logic                 fill_overrun
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS_PER_FRAME - 1);
   localparam logic [ADDR_W-1:0] NUM_PIX  = ADDR_W'(PIXELS_PER_FRAME);

   logic [PIXEL_W-1:0] mem [0:1][0:PIXELS_PER_FRAME-1];

   logic              wr_bank;
   logic              rd_bank;
   logic [1:0]        bank_full;
   logic [1:0]        bank_full_nxt;
   logic [ADDR_W-1:0] fill_cnt;
   logic              frame_valid;
   logic              xfer;
   logic              fill_done;
   logic              release_frame;
   logic              unused_wdata;

   assign pix_in_ready  = ~bank_full[wr_bank];
   assign frame_valid   = bank_full[rd_bank];
   assign xfer          = pix_in_valid & pix_in_ready;
   assign fill_done     = xfer & (fill_cnt == LAST_PIX);
   assign release_frame = classifier_input_valid_write_en & ~classifier_input_valid_write_data[0]
                          & frame_valid;
   assign unused_wdata  = ^classifier_input_valid_write_data[7:1];

   assign classifier_input_valid_read_data = {7'b0, frame_valid};

   // Fill and release hit different bits whenever both fire, so the order here is irrelevant.
   always_comb begin
      bank_full_nxt = bank_full;
      if (fill_done)
         bank_full_nxt[wr_bank] = 1'b1;
      if (release_frame)
         bank_full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         bank_full    <= 2'b00;
         fill_cnt     <= '0;
         fill_overrun <= 1'b0;
      end else begin
         bank_full <= bank_full_nxt;
         if (xfer) begin
            if (fill_done) begin
               fill_cnt <= '0;
               wr_bank  <= ~wr_bank;
            end else begin
               fill_cnt <= fill_cnt + 1'b1;
            end
         end
         if (release_frame)
            rd_bank <= ~rd_bank;
         if (pix_in_valid & ~pix_in_ready)
            fill_overrun <= 1'b1;
      end
   end

   // Storage is deliberately left unreset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (xfer)
         mem[wr_bank][fill_cnt] <= pix_in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         classifier_input_read_data_a <= '0;
      else if (classifier_input_address_a < NUM_PIX)
         classifier_input_read_data_a <= RD_DATA_W'(mem[rd_bank][classifier_input_address_a]);
      else
         classifier_input_read_data_a <= '0;
   end

`ifdef FEEDER_FRAME_STATS_EN
   assign frames_pending = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         frames_released <= 16'h0000;
      else if (release_frame)
         frames_released <= frames_released + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_classifier_frame_feeder.sv
// Directed bench for classifier_frame_feeder: fill, read, release, backpressure, simultaneous events, async reset.
module tb_classifier_frame_feeder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  pix_in_data;
   logic        pix_in_valid;
   logic        pix_in_ready;
   logic [9:0]  address;
   logic [15:0] read_data;
   logic [7:0]  valid_read_data;
   logic        write_en;
   logic [7:0]  write_data;
   logic        fill_overrun;
`ifdef FEEDER_FRAME_STATS_EN
   logic [15:0] frames_released;
   logic [1:0]  frames_pending;
`endif

   int errors = 0;
   int checks = 0;

   classifier_frame_feeder dut (
      .clk                               (clk),
      .reset_n                           (reset_n),
      .pix_in_data                       (pix_in_data),
      .pix_in_valid                      (pix_in_valid),
      .pix_in_ready                      (pix_in_ready),
      .classifier_input_address_a        (address),
      .classifier_input_read_data_a      (read_data),
      .classifier_input_valid_read_data  (valid_read_data),
      .classifier_input_valid_write_en   (write_en),
      .classifier_input_valid_write_data (write_data),
`ifdef FEEDER_FRAME_STATS_EN
      .frames_released                   (frames_released),
      .frames_pending                    (frames_pending),
`endif
      .fill_overrun                      (fill_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      pix_in_data  = d;
      pix_in_valid = 1'b1;
      step();
      pix_in_valid = 1'b0;
   endtask

   task automatic release_wr(input logic [7:0] d);
      write_en   = 1'b1;
      write_data = d;
      step();
      write_en   = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a, output logic [15:0] d);
      address = a;
      step();
      d = read_data;
   endtask

   logic [15:0] r;

   initial begin
      reset_n = 1'b0; pix_in_data = '0; pix_in_valid = 1'b0;
      address = '0; write_en = 1'b0; write_data = '0;
      #1;
      chk("reset_ready", 32'(pix_in_ready), 32'h1);
      chk("reset_valid", 32'(valid_read_data), 32'h00);
      chk("reset_rdata", 32'(read_data), 32'h0000);
      chk("reset_overrun", 32'(fill_overrun), 32'h0);
      #11 reset_n = 1'b1;
      step();

      // Frame A into bank 0: data = index[7:0]
      for (int i = 0; i < 783; i++) push(8'(i));
      chk("valid_before_last", 32'(valid_read_data), 32'h00);
      push(8'(783));
      chk("valid_after_frame", 32'(valid_read_data), 32'h01);
      chk("ready_after_frame", 32'(pix_in_ready), 32'h1);
      rd(10'd5, r);   chk("read_addr5", 32'(r), 32'h0005);
      rd(10'd783, r); chk("read_addr783", 32'(r), 32'h000F);
      rd(10'd800, r); chk("read_out_of_range", 32'(r), 32'h0000);

      release_wr(8'h01);
      chk("ignored_set_valid", 32'(valid_read_data), 32'h01);
      rd(10'd5, r);   chk("ignored_set_rdbank", 32'(r), 32'h0005);

      // Frame B (all AA) into bank 1, then both banks full
      for (int i = 0; i < 784; i++) push(8'hAA);
      chk("both_full_ready", 32'(pix_in_ready), 32'h0);
`ifdef FEEDER_FRAME_STATS_EN
      chk("pending_two", 32'(frames_pending), 32'h2);
`endif
      push(8'h55);
      chk("overrun_set", 32'(fill_overrun), 32'h1);
      rd(10'd0, r);   chk("bank0_addr0", 32'(r), 32'h0000);

      release_wr(8'h00);
      chk("release_valid_stays", 32'(valid_read_data), 32'h01);
      chk("release_ready", 32'(pix_in_ready), 32'h1);
      chk("overrun_sticky", 32'(fill_overrun), 32'h1);
      rd(10'd0, r);   chk("bank1_addr0", 32'(r), 32'h00AA);
      rd(10'd1, r);   chk("overrun_not_stored", 32'(r), 32'h00AA);

      // Refill bank 0 with 33, release bank 1, then fill bank 1 with 77 while releasing bank 0
      for (int i = 0; i < 784; i++) push(8'h33);
      chk("refill_full_ready", 32'(pix_in_ready), 32'h0);
      release_wr(8'h00);
      rd(10'd0, r);   chk("bank0_refill_addr0", 32'(r), 32'h0033);
      for (int i = 0; i < 783; i++) push(8'h77);
      write_en = 1'b1; write_data = 8'h00;
      push(8'h77);
      write_en = 1'b0;
      chk("simul_valid", 32'(valid_read_data), 32'h01);
      chk("simul_ready", 32'(pix_in_ready), 32'h1);
      rd(10'd783, r); chk("simul_rdbank1", 32'(r), 32'h0077);
`ifdef FEEDER_FRAME_STATS_EN
      chk("released_three", 32'(frames_released), 32'h3);
      chk("pending_one", 32'(frames_pending), 32'h1);
`endif

      release_wr(8'h00);
      chk("all_released_valid", 32'(valid_read_data), 32'h00);
      release_wr(8'h00);
      chk("ignored_clear_valid", 32'(valid_read_data), 32'h00);
      rd(10'd0, r);   chk("ignored_clear_rdbank", 32'(r), 32'h0033);

      // Async reset mid-fill at pixel 400, off the clock edge
      for (int i = 0; i < 400; i++) push(8'h11);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_rdata", 32'(read_data), 32'h0000);
      chk("arst_overrun", 32'(fill_overrun), 32'h0);
      chk("arst_valid", 32'(valid_read_data), 32'h00);
`ifdef FEEDER_FRAME_STATS_EN
      chk("arst_released", 32'(frames_released), 32'h0);
`endif
      #2 reset_n = 1'b1;
      step();
      for (int i = 0; i < 783; i++) push(8'(i) ^ 8'h5A);
      chk("post_reset_not_valid", 32'(valid_read_data), 32'h00);
      push(8'(783) ^ 8'h5A);
      chk("post_reset_valid", 32'(valid_read_data), 32'h01);
      rd(10'd10, r);  chk("post_reset_addr10", 32'(r), 32'h0050);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
